// File: rtl/lcd_bus_8080.sv
// Write-only 8080-style LCD bus timing stage.
// Byte writes from the driver are queued in a FIFO and then replayed on the
// panel bus with programmable setup, WR-low and WR-high times.
module lcd_bus_8080 #(
  parameter int FIFO_AW = 4,
  parameter int T_SETUP = 1,
  parameter int T_WRL   = 2,
  parameter int T_WRH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_cd,
  input  logic               in_write,
  input  logic               ovf_clear,
  output logic               full,
  output logic               idle,
  output logic               overflow,
  output logic [FIFO_AW:0]   level,
  output logic [7:0]         lcd_data,
  output logic               lcd_cd,
  output logic               lcd_cs_n,
  output logic               lcd_wr_n,
  output logic               lcd_rd_n
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int T_MAX = (T_SETUP > T_WRL) ? ((T_SETUP > T_WRH) ? T_SETUP : T_WRH)
                                           : ((T_WRL > T_WRH) ? T_WRL : T_WRH);
  localparam int CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // Phase counter holds T-1 and transitions when it reaches zero.
  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_WRL   = CW'(T_WRL - 1);
  localparam logic [CW-1:0] LD_WRH   = CW'(T_WRH - 1);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRL,
    S_WRH
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [8:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wptr;
  logic [FIFO_AW-1:0]  rptr;
  logic                push;
  logic                pop;
  logic                idle_next;
  logic [FIFO_AW:0]    level_next;

  // Push/pop decisions and next occupancy; full is the registered pre-edge value.
  always_comb begin
    push       = in_write && !full;
    pop        = (level != '0) &&
                 ((state == S_IDLE) || ((state == S_WRH) && (cnt == '0)));
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LVL_ONE;
      2'b01:   level_next = level - LVL_ONE;
      default: level_next = level;
    endcase
    idle_next  = (level_next == '0) &&
                 ((state == S_IDLE) || ((state == S_WRH) && (cnt == '0) && !pop));
  end

  // FIFO storage; contents need no reset since pointers and level gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_cd, in_data};
  end

  // FIFO pointers, occupancy, full and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= level_next;
      full  <= (level_next == LVL_FULL);
      if (in_write && full) overflow <= 1'b1;
      else if (ovf_clear)   overflow <= 1'b0;
    end
  end

  // Bus sequencer: IDLE -> SETUP -> WRL -> WRH, chaining straight into SETUP
  // from WRH when more bytes are queued so CS stays low across a burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lcd_data <= 8'h00;
      lcd_cd   <= 1'b0;
      lcd_cs_n <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_rd_n <= 1'b1;
      idle     <= 1'b1;
    end else begin
      lcd_rd_n <= 1'b1;
      idle     <= idle_next;
      case (state)
        S_IDLE: begin
          if (pop) begin
            {lcd_cd, lcd_data} <= mem[rptr];
            lcd_cs_n <= 1'b0;
            cnt      <= LD_SETUP;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            lcd_wr_n <= 1'b0;
            cnt      <= LD_WRL;
            state    <= S_WRL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WRL: begin
          if (cnt == '0) begin
            lcd_wr_n <= 1'b1;
            cnt      <= LD_WRH;
            state    <= S_WRH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WRH: begin
          if (cnt == '0) begin
            if (pop) begin
              {lcd_cd, lcd_data} <= mem[rptr];
              cnt   <= LD_SETUP;
              state <= S_SETUP;
            end else begin
              lcd_cs_n <= 1'b1;
              state    <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_8080.sv
// Directed bench for lcd_bus_8080: default timing instance (a) plus a
// 3/1/4 timing instance (b).
module tb_lcd_bus_8080;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data = 8'h00;
  logic       in_cd = 1'b0, in_write = 1'b0, ovf_clear = 1'b0;
  logic       full, idle, overflow, lcd_cd, lcd_cs_n, lcd_wr_n, lcd_rd_n;
  logic [4:0] level;
  logic [7:0] lcd_data;

  logic [7:0] b_in_data = 8'h00;
  logic       b_in_cd = 1'b0, b_in_write = 1'b0, b_ovf_clear = 1'b0;
  logic       b_full, b_idle, b_overflow, b_lcd_cd, b_lcd_cs_n, b_lcd_wr_n, b_lcd_rd_n;
  logic [4:0] b_level;
  logic [7:0] b_lcd_data;

  lcd_bus_8080 u_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_cd(in_cd),
    .in_write(in_write), .ovf_clear(ovf_clear), .full(full), .idle(idle),
    .overflow(overflow), .level(level), .lcd_data(lcd_data), .lcd_cd(lcd_cd),
    .lcd_cs_n(lcd_cs_n), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n)
  );

  lcd_bus_8080 #(.FIFO_AW(4), .T_SETUP(3), .T_WRL(1), .T_WRH(4)) u_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_cd(b_in_cd),
    .in_write(b_in_write), .ovf_clear(b_ovf_clear), .full(b_full), .idle(b_idle),
    .overflow(b_overflow), .level(b_level), .lcd_data(b_lcd_data), .lcd_cd(b_lcd_cd),
    .lcd_cs_n(b_lcd_cs_n), .lcd_wr_n(b_lcd_wr_n), .lcd_rd_n(b_lcd_rd_n)
  );

  int vecs = 0;
  int errs = 0;

  // bus monitor state for instance a
  int         cyc = 0;
  logic       pw = 1'b1;
  logic [8:0] pdc = 9'h000;
  int         hold = 0;
  int         viol = 0;
  int         falls = 0;
  int         cs_gap = 0;
  bit         burst = 1'b0;
  logic [8:0] rise_q[$];
  int         rise_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge and update the monitor.
  task automatic step();
    logic changed;
    @(posedge clk);
    #1;
    cyc++;
    changed = ({lcd_cd, lcd_data} !== pdc);
    if (changed && (lcd_wr_n === 1'b0 || pw === 1'b0 || hold > 0)) viol++;
    if (pw === 1'b1 && lcd_wr_n === 1'b0) falls++;
    if (pw === 1'b0 && lcd_wr_n === 1'b1) begin
      rise_q.push_back({lcd_cd, lcd_data});
      rise_t.push_back(cyc);
      hold = 1;
    end else if (hold > 0) begin
      hold--;
    end
    if (burst && idle === 1'b0 && lcd_cs_n !== 1'b0) cs_gap++;
    pw  = lcd_wr_n;
    pdc = {lcd_cd, lcd_data};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] ed;

    // reset values
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_cd", lcd_cd, 0);
    chk("rst_cs", lcd_cs_n, 1);
    chk("rst_wr", lcd_wr_n, 1);
    chk("rst_rd", lcd_rd_n, 1);

    // single push 0xE2 command
    in_data = 8'hE2; in_cd = 1'b0; in_write = 1'b1;
    step();                       // E0
    in_write = 1'b0;
    chk("s_e0_level", level, 1);
    chk("s_e0_idle", idle, 0);
    chk("s_e0_cs", lcd_cs_n, 1);
    step();                       // E1
    chk("s_e1_data", lcd_data, 8'hE2);
    chk("s_e1_cd", lcd_cd, 0);
    chk("s_e1_cs", lcd_cs_n, 0);
    chk("s_e1_wr", lcd_wr_n, 1);
    chk("s_e1_level", level, 0);
    step(); chk("s_e2_wr", lcd_wr_n, 0);
    step(); chk("s_e3_wr", lcd_wr_n, 0);
    step(); chk("s_e4_wr", lcd_wr_n, 1);
    step(); chk("s_e5_idle", idle, 0); chk("s_e5_cs", lcd_cs_n, 0);
    step(); chk("s_e6_idle", idle, 1); chk("s_e6_cs", lcd_cs_n, 1);

    // burst until full, then overflow with simultaneous clear
    rise_q.delete(); rise_t.delete(); viol = 0; cs_gap = 0;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i); in_cd = 1'b1; in_write = 1'b1;
      step();
      burst = 1'b1;
      if (i == 18) chk("b_full_early", full, 0);
    end
    chk("b_full", full, 1);
    chk("b_level16", level, 16);
    in_data = 8'hAA; ovf_clear = 1'b1;
    step();                       // push while full
    in_write = 1'b0;
    chk("b_ovf_set", overflow, 1);
    chk("b_level_hold", level, 16);
    step();                       // clear alone
    ovf_clear = 1'b0;
    chk("b_ovf_clr", overflow, 0);
    chk("b_level15", level, 15);
    n = 0;
    while (idle !== 1'b1 && n < 200) begin step(); n++; end
    burst = 1'b0;
    chk("b_drain_timeout", idle, 1);
    chk("b_count", rise_q.size(), 20);
    for (int i = 0; i < 20 && i < rise_q.size(); i++) begin
      chk("b_byte", rise_q[i], {1'b1, 8'(i)});
      if (i > 0) chk("b_period", 32'(rise_t[i] - rise_t[i-1]), 5);
    end
    chk("b_cs_gap", cs_gap, 0);
    chk("b_hold_viol", viol, 0);

    // alternating C/D
    rise_q.delete(); rise_t.delete(); viol = 0;
    in_data = 8'h81; in_cd = 1'b0; in_write = 1'b1;
    step();                       // E0
    in_data = 8'h00; in_cd = 1'b1;
    step();                       // E1
    in_write = 1'b0;
    chk("c_e1_data", lcd_data, 8'h81);
    chk("c_e1_cd", lcd_cd, 0);
    repeat (4) step();            // E5
    chk("c_e5_cd", lcd_cd, 0);
    chk("c_e5_wr", lcd_wr_n, 1);
    step();                       // E6
    chk("c_e6_cd", lcd_cd, 1);
    chk("c_e6_data", lcd_data, 8'h00);
    n = 0;
    while (idle !== 1'b1 && n < 50) begin step(); n++; end
    chk("c_drain_timeout", idle, 1);
    chk("c_count", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      chk("c_first", rise_q[0], 9'h081);
      chk("c_second", rise_q[1], 9'h100);
    end
    chk("c_hold_viol", viol, 0);

    // instance b: T_SETUP=3, T_WRL=1, T_WRH=4
    b_in_data = 8'h3C; b_in_write = 1'b1;
    step();                       // E0
    chk("t_e0_cs", b_lcd_cs_n, 1);
    b_in_data = 8'hC3;
    step();                       // E1
    b_in_write = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) step();
      ed = (c <= 8) ? 8'h3C : 8'hC3;
      chk("t_wr", b_lcd_wr_n, (c == 4 || c == 12) ? 0 : 1);
      chk("t_data", b_lcd_data, ed);
      chk("t_cs", b_lcd_cs_n, (c == 17) ? 1 : 0);
      chk("t_idle", b_idle, (c == 17) ? 1 : 0);
    end

    // reset in the middle of a strobe with 5 bytes queued
    for (int i = 0; i < 7; i++) begin
      in_data = 8'(8'h50 + i); in_cd = 1'b0; in_write = 1'b1;
      step();
    end
    in_write = 1'b0;
    n = 0;
    while (!(lcd_wr_n === 1'b0 && level === 5'd5) && n < 50) begin step(); n++; end
    chk("r_found", {lcd_wr_n, level}, {1'b0, 5'd5});
    reset = 1'b1;
    step();
    chk("r_wr", lcd_wr_n, 1);
    chk("r_cs", lcd_cs_n, 1);
    chk("r_level", level, 0);
    chk("r_idle", idle, 1);
    chk("r_full", full, 0);
    reset = 1'b0;
    falls = 0;
    repeat (20) step();
    chk("r_no_strobe", falls, 0);
    chk("r_still_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
